// File: rtl/ex_stage.sv
// Execute stage: ALU, branch-target add and zero flag, registered into EX_MEM,
// plus a SIZE-cycle shift-add multiplier that stalls decode via id_ready.
module ex_stage #(
    parameter int unsigned SIZE = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [$clog2(SIZE)+4*SIZE+10-1:0]    ID_EX,
    input  logic                                 id_valid,
    output logic                                 id_ready,
    output logic [$clog2(SIZE)+3*SIZE+6-1:0]     EX_MEM,
    output logic                                 ex_valid,
    input  logic                                 mem_ready
);

    localparam int unsigned RW      = $clog2(SIZE);
    localparam int unsigned IW      = RW + 4*SIZE + 10;
    localparam int unsigned EW      = RW + 3*SIZE + 6;
    localparam int unsigned IMM_LSB = 10;
    localparam int unsigned RD2_LSB = 10 + SIZE;
    localparam int unsigned RD1_LSB = 10 + 2*SIZE;
    localparam int unsigned PC4_LSB = 10 + 3*SIZE;
    localparam int unsigned WR_LSB  = 10 + 4*SIZE;
    localparam int unsigned C_BRANCH   = 7;
    localparam int unsigned C_MEMREAD  = 6;
    localparam int unsigned C_MEMTOREG = 5;
    localparam int unsigned C_MEMWRITE = 2;
    localparam int unsigned C_ALUSRC   = 1;
    localparam int unsigned C_REGWRITE = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     cnt_q, cnt_d;
    logic [SIZE-1:0]   acc_q, acc_d;
    logic [IW-1:0]     id_q, id_d;
    logic [EW-1:0]     ex_mem_q, ex_mem_d;
    logic              ex_valid_q, ex_valid_d;

    // Incoming instruction fields
    logic [SIZE-1:0]   in_rd1, in_rd2, in_imm, in_opb, alu_res;
    logic [1:0]        in_aluop;
    logic [5:0]        in_funct;
    logic [4:0]        in_shamt;
    logic              in_is_mult;

    assign in_rd1     = ID_EX[RD1_LSB +: SIZE];
    assign in_rd2     = ID_EX[RD2_LSB +: SIZE];
    assign in_imm     = ID_EX[IMM_LSB +: SIZE];
    assign in_opb     = ID_EX[C_ALUSRC] ? in_imm : in_rd2;
    assign in_aluop   = ID_EX[4:3];
    assign in_funct   = in_imm[5:0];
    assign in_shamt   = in_imm[10:6];
    assign in_is_mult = (in_aluop == 2'b10) && (in_funct == 6'h18);

    // Single-cycle ALU; mult is produced by the sequential multiplier instead
    always_comb begin
        alu_res = '0;
        case (in_aluop)
            2'b00: alu_res = in_rd1 + in_opb;
            2'b01: alu_res = in_rd1 - in_opb;
            2'b11: alu_res = in_rd1 | in_opb;
            default: begin
                case (in_funct)
                    6'h20:   alu_res = in_rd1 + in_opb;
                    6'h22:   alu_res = in_rd1 - in_opb;
                    6'h24:   alu_res = in_rd1 & in_opb;
                    6'h25:   alu_res = in_rd1 | in_opb;
                    6'h27:   alu_res = ~(in_rd1 | in_opb);
                    6'h2A:   alu_res = SIZE'($signed(in_rd1) < $signed(in_opb));
                    6'h00:   alu_res = in_rd2 << in_shamt;
                    default: alu_res = '0;
                endcase
            end
        endcase
    end

    logic [SIZE-1:0]   mul_mcand, mul_mplier;
    assign mul_mcand  = id_q[RD1_LSB +: SIZE];
    assign mul_mplier = id_q[C_ALUSRC] ? id_q[IMM_LSB +: SIZE] : id_q[RD2_LSB +: SIZE];

    // EX_MEM image built from the live bundle, or from the latched one when a mult retires
    logic [IW-1:0]     out_bus;
    logic [SIZE-1:0]   out_res, out_bt;
    logic [EW-1:0]     out_word;
    logic              unused_bits;

    assign out_bus  = (state_q == S_DONE) ? id_q : ID_EX;
    assign out_res  = (state_q == S_DONE) ? acc_q : alu_res;
    assign out_bt   = out_bus[PC4_LSB +: SIZE] + (out_bus[IMM_LSB +: SIZE] << 2);
    assign out_word = {out_bus[WR_LSB +: RW], out_bt, out_res, out_bus[RD2_LSB +: SIZE],
                       (out_res == '0), out_bus[C_BRANCH], out_bus[C_MEMREAD],
                       out_bus[C_MEMTOREG], out_bus[C_MEMWRITE], out_bus[C_REGWRITE]};
    assign unused_bits = ^{out_bus[RD1_LSB +: SIZE], out_bus[9:8], out_bus[4:3], out_bus[C_ALUSRC]};

    logic slot_free;
    assign slot_free = !ex_valid_q || mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            id_q       <= '0;
            ex_mem_q   <= '0;
            ex_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            id_q       <= id_d;
            ex_mem_q   <= ex_mem_d;
            ex_valid_q <= ex_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        id_d       = id_q;
        ex_mem_d   = ex_mem_q;
        ex_valid_d = ex_valid_q;
        id_ready   = 1'b0;
        // A consumed (or empty) slot goes invalid unless refilled below
        if (slot_free) begin
            ex_valid_d = 1'b0;
        end
        case (state_q)
            S_IDLE: begin
                id_ready = slot_free;
                if (id_valid && slot_free) begin
                    if (in_is_mult) begin
                        id_d    = ID_EX;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else begin
                        ex_mem_d   = out_word;
                        ex_valid_d = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (mul_mcand[cnt_q]) begin
                    acc_d = acc_q + (mul_mplier << cnt_q);
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RW'(SIZE - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (slot_free) begin
                    ex_mem_d   = out_word;
                    ex_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign EX_MEM   = ex_mem_q;
    assign ex_valid = ex_valid_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus random traffic
// compared against a cycle-count/arithmetic reference model.
module tb_ex_stage;

    localparam int unsigned SIZE = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned IW   = RW + 4*SIZE + 10;
    localparam int unsigned EW   = RW + 3*SIZE + 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [IW-1:0]   id_ex;
    logic            id_valid;
    logic            id_ready;
    logic [EW-1:0]   ex_mem;
    logic            ex_valid;
    logic            mem_ready;

    int checks = 0;
    int errors = 0;

    logic            m_valid;
    logic [EW-1:0]   m_out, m_pend;
    int              m_busy;

    ex_stage #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .ID_EX     (id_ex),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .EX_MEM    (ex_mem),
        .ex_valid  (ex_valid),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mk(input logic [RW-1:0] wr, input logic [31:0] pc4,
                                         input logic [31:0] rd1, input logic [31:0] rd2,
                                         input logic [31:0] imm, input logic [9:0] ctrl);
        return {wr, pc4, rd1, rd2, imm, ctrl};
    endfunction

    function automatic logic [9:0] ctl(input logic [1:0] op, input logic alusrc,
                                       input logic branch, input logic regwrite);
        return {1'b0, 1'b0, branch, 1'b0, 1'b0, op, 1'b0, alusrc, regwrite};
    endfunction

    function automatic logic is_mult(input logic [IW-1:0] b);
        logic [9:0]  c;
        logic [31:0] imm;
        c   = b[9:0];
        imm = b[10 +: 32];
        return (c[4:3] == 2'b10) && (imm[5:0] == 6'h18);
    endfunction

    // Reference result of one instruction, from the arithmetic definitions
    function automatic logic [EW-1:0] ref_out(input logic [IW-1:0] b);
        logic [9:0]  c;
        logic [31:0] imm, rd2, rd1, pc4, opb, res, bt;
        logic [4:0]  wr;
        logic [63:0] prod;
        c   = b[9:0];
        imm = b[10 +: 32];
        rd2 = b[42 +: 32];
        rd1 = b[74 +: 32];
        pc4 = b[106 +: 32];
        wr  = b[138 +: 5];
        opb = c[1] ? imm : rd2;
        res = 32'd0;
        case (c[4:3])
            2'b00: res = rd1 + opb;
            2'b01: res = rd1 - opb;
            2'b11: res = rd1 | opb;
            default: begin
                case (imm[5:0])
                    6'h20: res = rd1 + opb;
                    6'h22: res = rd1 - opb;
                    6'h24: res = rd1 & opb;
                    6'h25: res = rd1 | opb;
                    6'h27: res = ~(rd1 | opb);
                    6'h2A: res = ($signed(rd1) < $signed(opb)) ? 32'd1 : 32'd0;
                    6'h00: res = rd2 << imm[10:6];
                    6'h18: begin
                        prod = 64'(rd1) * 64'(opb);
                        res  = prod[31:0];
                    end
                    default: res = 32'd0;
                endcase
            end
        endcase
        bt = pc4 + imm * 32'd4;
        return {wr, bt, res, rd2, (res == 32'd0), c[7], c[6], c[5], c[2], c[0]};
    endfunction

    task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        id_valid  = 1'b0;
        id_ex     = '0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_valid = 1'b0;
        m_out   = '0;
        m_pend  = '0;
        m_busy  = 0;
    endtask

    // One clock of traffic: drive, check id_ready, advance the model, check registered outputs
    task automatic cycle(input logic v, input logic [IW-1:0] b, input logic mr);
        logic free, exp_rdy;
        id_valid  = v;
        id_ex     = b;
        mem_ready = mr;
        #1;
        free    = !m_valid || mr;
        exp_rdy = (m_busy == 0) && free;
        chk("id_ready", EW'(id_ready), EW'(exp_rdy));
        if (m_busy > 1) begin
            m_busy--;
            if (free) m_valid = 1'b0;
        end else if (m_busy == 1) begin
            if (free) begin
                m_out   = m_pend;
                m_valid = 1'b1;
                m_busy  = 0;
            end
        end else if (v && exp_rdy) begin
            if (is_mult(b)) begin
                m_pend = ref_out(b);
                m_busy = SIZE + 1;
                if (free) m_valid = 1'b0;
            end else begin
                m_out   = ref_out(b);
                m_valid = 1'b1;
            end
        end else if (free) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("ex_valid", EW'(ex_valid), EW'(m_valid));
        if (m_valid) chk("ex_mem", ex_mem, m_out);
    endtask

    function automatic logic [31:0] alu_of(input logic [EW-1:0] e);
        return e[6 + SIZE +: SIZE];
    endfunction

    initial begin
        logic [IW-1:0] b;
        logic [EW-1:0] snap;
        logic [31:0]   r, imm;
        logic [5:0]    f;
        int            n;

        do_reset();
        chk("rst_ex_valid", EW'(ex_valid), '0);
        chk("rst_ex_mem", ex_mem, '0);
        chk("rst_id_ready", EW'(id_ready), EW'(1));

        // R-type add
        cycle(1'b1, mk(5'd3, 32'h0, 32'd5, 32'd7, 32'h20, ctl(2'b10, 1'b0, 1'b0, 1'b1)), 1'b1);
        chk("add_alu", EW'(alu_of(ex_mem)), EW'(12));
        chk("add_wr", EW'(ex_mem[6 + 3*SIZE +: RW]), EW'(3));
        chk("add_regwrite", EW'(ex_mem[0]), EW'(1));

        // sub to zero, branch target
        cycle(1'b1, mk(5'd0, 32'h100, 32'h1234, 32'h1234, 32'd4, ctl(2'b01, 1'b0, 1'b1, 1'b0)), 1'b1);
        chk("sub_alu", EW'(alu_of(ex_mem)), EW'(0));
        chk("sub_zero", EW'(ex_mem[5]), EW'(1));
        chk("branch_target", EW'(ex_mem[6 + 2*SIZE +: SIZE]), EW'(32'h110));

        // signed slt both ways
        cycle(1'b1, mk(5'd1, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h2A, ctl(2'b10, 1'b0, 1'b0, 1'b1)), 1'b1);
        chk("slt_neg", EW'(alu_of(ex_mem)), EW'(1));
        cycle(1'b1, mk(5'd1, 32'h0, 32'd1, 32'hFFFF_FFFF, 32'h2A, ctl(2'b10, 1'b0, 1'b0, 1'b1)), 1'b1);
        chk("slt_pos", EW'(alu_of(ex_mem)), EW'(0));

        // multiply 6*7 with latency measurement
        cycle(1'b1, mk(5'd4, 32'h0, 32'd6, 32'd7, 32'h18, ctl(2'b10, 1'b0, 1'b0, 1'b1)), 1'b1);
        n = 0;
        do begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end while (!ex_valid && n < 40);
        chk("mult_latency", EW'(n), EW'(33));
        chk("mult_6x7", EW'(alu_of(ex_mem)), EW'(42));

        cycle(1'b1, mk(5'd4, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h18, ctl(2'b10, 1'b0, 1'b0, 1'b1)), 1'b1);
        n = 0;
        do begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end while (!ex_valid && n < 40);
        chk("mult_max_valid", EW'(ex_valid), EW'(1));
        chk("mult_max", EW'(alu_of(ex_mem)), EW'(1));

        // backpressure hold, then release and full throughput
        cycle(1'b1, mk(5'd2, 32'h40, 32'd10, 32'd20, 32'h20, ctl(2'b10, 1'b0, 1'b0, 1'b1)), 1'b1);
        snap = ex_mem;
        b = mk(5'd5, 32'h80, 32'd100, 32'd1, 32'h20, ctl(2'b10, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, b, 1'b0);
            chk("bp_hold", ex_mem, snap);
            chk("bp_id_ready", EW'(id_ready), EW'(0));
        end
        cycle(1'b1, b, 1'b1);
        chk("bp_release", EW'(alu_of(ex_mem)), EW'(101));
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, mk(5'd6, 32'h0, 32'(i), 32'd200, 32'd0, ctl(2'b00, 1'b0, 1'b0, 1'b1)), 1'b1);
            chk("b2b_add", EW'(alu_of(ex_mem)), EW'(200 + i));
        end

        // reset in the middle of a multiply
        cycle(1'b1, mk(5'd7, 32'h0, 32'd9, 32'd9, 32'h18, ctl(2'b10, 1'b0, 1'b0, 1'b1)), 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
        do_reset();
        chk("midrst_ex_valid", EW'(ex_valid), '0);
        chk("midrst_ex_mem", ex_mem, '0);
        chk("midrst_id_ready", EW'(id_ready), EW'(1));
        cycle(1'b1, mk(5'd8, 32'h0, 32'd1, 32'd1, 32'h20, ctl(2'b10, 1'b0, 1'b0, 1'b1)), 1'b1);
        chk("post_rst_add", EW'(alu_of(ex_mem)), EW'(2));
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            r = $urandom;
            case ($urandom_range(0, 9))
                0: f = 6'h20;
                1: f = 6'h22;
                2: f = 6'h24;
                3: f = 6'h25;
                4: f = 6'h27;
                5: f = 6'h2A;
                6: f = 6'h00;
                7: f = ($urandom_range(0, 3) == 0) ? 6'h18 : 6'h20;
                default: f = 6'($urandom);
            endcase
            imm = {r[31:6], f};
            b = mk(5'($urandom), $urandom, $urandom, $urandom, imm, 10'($urandom));
            cycle(($urandom_range(0, 3) != 0), b, ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
